mmio_hub: RTL and testbench

//  Parametrised MMIO decoder and interrupt aggregator between OTTER_MCU IOBUS and board peripherals.

---
 rtl/mmio_hub_pkg.sv | 29 ++
 rtl/mmio_hub_irq.sv | 41 ++++
 rtl/mmio_hub.sv | 97 +++++++++
 tb/tb_mmio_hub.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_hub_pkg.sv
// Shared slot encoding and address decode for the MMIO hub.
// Slots 62/63 are reserved for the interrupt controller registers.
package mmio_hub_pkg;

    localparam int SLOT_W = 6;

    typedef logic [SLOT_W-1:0] slot_t;

    localparam slot_t SLOT_MASK = 6'd62;
    localparam slot_t SLOT_PEND = 6'd63;

    typedef struct packed {
        logic  hit;
        slot_t slot;
    } decode_t;

    // Window match on the bits above the slot field; slot base must be exactly aligned.
    function automatic decode_t decode(input logic [31:0] addr, input logic [31:0] base,
                                       input int stride_shift);
        decode_t d;
        logic [31:0] low_mask;
        low_mask = (32'd1 << stride_shift) - 32'd1;
        d.hit  = ((addr >> (stride_shift + SLOT_W)) == (base >> (stride_shift + SLOT_W)))
                 && ((addr & low_mask) == 32'd0);
        d.slot = slot_t'(addr >> stride_shift);
        return d;
    endfunction

endpackage

// File: rtl/mmio_hub_irq.sv
// Edge-triggered interrupt aggregator: rising-edge detect, sticky pending bits,
// write-1-to-clear acknowledge, enable mask and a registered INTR output.
module irq_aggregator #(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] src,
    input  logic             mask_we,
    input  logic             ack_we,
    input  logic [N_IRQ-1:0] wdata,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] pend,
    output logic             intr
);

    logic [N_IRQ-1:0] src_prev;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] ack;

    assign rise = src & ~src_prev;
    assign ack  = ack_we ? wdata : '0;

    // src_prev resets to all-ones so a source already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_prev <= '1;
            mask     <= '0;
            pend     <= '0;
            intr     <= 1'b0;
        end else begin
            src_prev <= src;
            if (mask_we) begin
                mask <= wdata;
            end
            pend <= (pend & ~ack) | rise;
            intr <= |(pend & mask);
        end
    end

endmodule

// File: rtl/mmio_hub.sv
// MMIO decoder between the MCU IOBUS and board peripherals: input read slots,
// registered output slots with one-cycle write strobes, and the interrupt aggregator.
module mmio_hub
    import mmio_hub_pkg::*;
#(
    parameter logic [31:0] BASE_AD      = 32'h11000000,
    parameter int          STRIDE_SHIFT = 18,
    parameter int          N_IN         = 8,
    parameter int          N_OUT        = 8,
    parameter int          N_IRQ        = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [31:0]         IOBUS_ADDR,
    input  logic [31:0]         IOBUS_OUT,
    input  logic                IOBUS_WR,
    output logic [31:0]         IOBUS_IN,
    input  logic [N_IN*32-1:0]  IN_DATA,
    output logic [N_OUT*32-1:0] OUT_DATA,
    output logic [N_OUT-1:0]    OUT_WE,
    input  logic [N_IRQ-1:0]    IRQ_SRC,
    output logic                INTR
);

    if (N_IN < 1 || N_IN > 62) begin : g_bad_n_in
        $error("mmio_hub: N_IN must be in 1..62");
    end
    if (N_OUT < 1 || N_OUT > 62) begin : g_bad_n_out
        $error("mmio_hub: N_OUT must be in 1..62");
    end
    if (N_IRQ < 1 || N_IRQ > 32) begin : g_bad_n_irq
        $error("mmio_hub: N_IRQ must be in 1..32");
    end

    decode_t          dec;
    logic             wr_hit;
    logic [N_IRQ-1:0] irq_mask;
    logic [N_IRQ-1:0] irq_pend;
    logic [31:0]      mask_ext;
    logic [31:0]      pend_ext;

    assign dec    = decode(IOBUS_ADDR, BASE_AD, STRIDE_SHIFT);
    assign wr_hit = IOBUS_WR & dec.hit;

    // Strobes default low every cycle so each write yields exactly one strobe cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            OUT_DATA <= '0;
            OUT_WE   <= '0;
        end else begin
            OUT_WE <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                if (wr_hit && dec.slot == slot_t'(j)) begin
                    OUT_DATA[32*j +: 32] <= IOBUS_OUT;
                    OUT_WE[j]            <= 1'b1;
                end
            end
        end
    end

    irq_aggregator #(.N_IRQ(N_IRQ)) u_irq (
        .clk     (CLK),
        .rst_n   (RST_N),
        .src     (IRQ_SRC),
        .mask_we (wr_hit && dec.slot == SLOT_MASK),
        .ack_we  (wr_hit && dec.slot == SLOT_PEND),
        .wdata   (IOBUS_OUT[N_IRQ-1:0]),
        .mask    (irq_mask),
        .pend    (irq_pend),
        .intr    (INTR)
    );

    always_comb begin
        mask_ext              = '0;
        pend_ext              = '0;
        mask_ext[N_IRQ-1:0]   = irq_mask;
        pend_ext[N_IRQ-1:0]   = irq_pend;
    end

    always_comb begin
        IOBUS_IN = '0;
        if (dec.hit) begin
            for (int i = 0; i < N_IN; i++) begin
                if (dec.slot == slot_t'(i)) begin
                    IOBUS_IN = IN_DATA[32*i +: 32];
                end
            end
            if (dec.slot == SLOT_MASK) begin
                IOBUS_IN = mask_ext;
            end
            if (dec.slot == SLOT_PEND) begin
                IOBUS_IN = pend_ext;
            end
        end
    end

endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: output slots, read mux, interrupt edge/pend/mask/ack timing.
module tb_mmio_hub;

    localparam logic [31:0] A_MASK = 32'h11F80000;
    localparam logic [31:0] A_PEND = 32'h11FC0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  iobus_addr;
    logic [31:0]  iobus_out;
    logic         iobus_wr;
    logic [31:0]  iobus_in;
    logic [255:0] in_data;
    logic [255:0] out_data;
    logic [7:0]   out_we;
    logic [3:0]   irq_src;
    logic         intr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] rd;
    logic [31:0] model_out [8];

    mmio_hub dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .IOBUS_ADDR (iobus_addr),
        .IOBUS_OUT  (iobus_out),
        .IOBUS_WR   (iobus_wr),
        .IOBUS_IN   (iobus_in),
        .IN_DATA    (in_data),
        .OUT_DATA   (out_data),
        .OUT_WE     (out_we),
        .IRQ_SRC    (irq_src),
        .INTR       (intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        iobus_addr = addr;
        iobus_out  = data;
        iobus_wr   = 1'b1;
        tick();
        iobus_wr   = 1'b0;
        iobus_addr = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        iobus_wr   = 1'b0;
        iobus_addr = addr;
        #1;
        data = iobus_in;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        irq_src  = 4'hF;
        iobus_wr = 1'b0;
        iobus_addr = 32'h0;
        iobus_out  = 32'h0;
        in_data  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (intr !== 1'b0) begin
            n_fail++; $display("FAIL reset_intr got=%b exp=0", intr);
        end
        n_checks++;
        if (out_data !== 256'h0) begin
            n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        n_checks++;
        if (out_we !== 8'h0) begin
            n_fail++; $display("FAIL reset_out_we got=%b exp=0", out_we);
        end
        exp_q.push_back(32'h0);
        bus_read(A_PEND, rd);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd !== exp_v) begin
            n_fail++; $display("FAIL reset_pend_held_src got=%h exp=%h", rd, exp_v);
        end
        irq_src = 4'h0;
        tick();
        for (int i = 0; i < 8; i++) model_out[i] = 32'h0;
    endtask

    task automatic test_write();
        exp_q.push_back(32'hDEADBEEF);
        model_out[1] = 32'hDEADBEEF;
        bus_write(32'h11040000, 32'hDEADBEEF);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (out_data[63:32] !== exp_v) begin
            n_fail++; $display("FAIL write_slot1_data got=%h exp=%h", out_data[63:32], exp_v);
        end
        n_checks++;
        if (out_we !== 8'b0000_0010) begin
            n_fail++; $display("FAIL write_slot1_we got=%b exp=00000010", out_we);
        end
        tick();
        n_checks++;
        if (out_we !== 8'h0) begin
            n_fail++; $display("FAIL write_we_one_cycle got=%b exp=0", out_we);
        end
        n_checks++;
        if (out_data[63:32] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_hold got=%h exp=deadbeef", out_data[63:32]);
        end
        // Misses: wrong window, misaligned, unimplemented slot
        bus_write(32'h12040000, 32'h11111111);
        n_checks++;
        if (out_we !== 8'h0 || out_data[63:32] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_miss_window we=%b d1=%h exp we=0 d1=deadbeef", out_we, out_data[63:32]);
        end
        bus_write(32'h11040004, 32'h22222222);
        n_checks++;
        if (out_we !== 8'h0 || out_data[63:32] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_misaligned we=%b d1=%h exp we=0 d1=deadbeef", out_we, out_data[63:32]);
        end
        bus_write(32'h11000000 + (32'd20 << 18), 32'h33333333);
        n_checks++;
        if (out_we !== 8'h0 || out_data !== {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin
            n_fail++; $display("FAIL write_unused_slot we=%b data=%h", out_we, out_data);
        end
    endtask

    task automatic test_read();
        in_data[95:64] = 32'h1234;
        exp_q.push_back(32'h1234);
        bus_read(32'h11080000, rd);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd !== exp_v) begin
            n_fail++; $display("FAIL read_slot2 got=%h exp=%h", rd, exp_v);
        end
        exp_q.push_back(32'h0);
        bus_read(32'h11040004, rd);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rd !== exp_v || out_we !== 8'h0) begin
            n_fail++; $display("FAIL read_misaligned got=%h we=%b exp=%h we=0", rd, out_we, exp_v);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom_range(32'h7FFFFFFF, 0);
            in_data[32*i +: 32] = v;
            exp_q.push_back(v);
        end
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = 32'h11000000 + (32'(i) << 18);
            bus_read(a, rd);
            exp_v = (i < 8) ? exp_q.pop_front() : 32'h0;
            n_checks++;
            if (rd !== exp_v) begin
                n_fail++; $display("FAIL read_slot%0d got=%h exp=%h", i, rd, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_irq_basic();
        bus_write(A_MASK, 32'h4);
        irq_src[2] = 1'b1;
        tick();
        irq_src[2] = 1'b0;
        bus_read(A_PEND, rd);
        n_checks++;
        if (rd !== 32'h4 || intr !== 1'b0) begin
            n_fail++; $display("FAIL irq_basic_pend pend=%h intr=%b exp pend=4 intr=0", rd, intr);
        end
        tick();
        n_checks++;
        if (intr !== 1'b1) begin
            n_fail++; $display("FAIL irq_basic_intr_rise got=%b exp=1", intr);
        end
        bus_write(A_PEND, 32'h4);
        bus_read(A_PEND, rd);
        n_checks++;
        if (rd !== 32'h0 || intr !== 1'b1) begin
            n_fail++; $display("FAIL irq_basic_ack pend=%h intr=%b exp pend=0 intr=1", rd, intr);
        end
        tick();
        n_checks++;
        if (intr !== 1'b0) begin
            n_fail++; $display("FAIL irq_basic_intr_fall got=%b exp=0", intr);
        end
    endtask

    task automatic test_irq_masked();
        bus_write(A_MASK, 32'h0);
        irq_src[0] = 1'b1;
        tick();
        irq_src[0] = 1'b0;
        tick();
        tick();
        bus_read(A_PEND, rd);
        n_checks++;
        if (rd !== 32'h1 || intr !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked_pend pend=%h intr=%b exp pend=1 intr=0", rd, intr);
        end
        bus_write(A_MASK, 32'h1);
        bus_read(A_MASK, rd);
        n_checks++;
        if (rd !== 32'h1 || intr !== 1'b0) begin
            n_fail++; $display("FAIL irq_unmask_edge mask=%h intr=%b exp mask=1 intr=0", rd, intr);
        end
        tick();
        n_checks++;
        if (intr !== 1'b1) begin
            n_fail++; $display("FAIL irq_unmask_intr got=%b exp=1", intr);
        end
        bus_write(A_PEND, 32'h1);
        tick();
        n_checks++;
        if (intr !== 1'b0) begin
            n_fail++; $display("FAIL irq_masked_ack got=%b exp=0", intr);
        end
    endtask

    task automatic test_irq_collision();
        bus_write(A_MASK, 32'h8);
        irq_src[3] = 1'b1;
        tick();
        irq_src[3] = 1'b0;
        tick();
        // New rise on bit 3 coinciding with its ack: set wins
        irq_src[3] = 1'b1;
        bus_write(A_PEND, 32'h8);
        bus_read(A_PEND, rd);
        n_checks++;
        if (rd !== 32'h8) begin
            n_fail++; $display("FAIL irq_set_wins pend=%h exp=8", rd);
        end
        bus_write(A_PEND, 32'h8);
        repeat (4) tick();
        bus_read(A_PEND, rd);
        n_checks++;
        if (rd !== 32'h0 || intr !== 1'b0) begin
            n_fail++; $display("FAIL irq_held_no_reedge pend=%h intr=%b exp pend=0 intr=0", rd, intr);
        end
        irq_src[3] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom();
            model_out[i] = v;
            exp_q.push_back(v);
            iobus_addr = 32'h11000000 + (32'(i) << 18);
            iobus_out  = v;
            iobus_wr   = 1'b1;
            tick();
            exp_v = exp_q.pop_front();
            n_checks++;
            if (out_we !== (8'h1 << i) || out_data[32*i +: 32] !== exp_v) begin
                n_fail++; $display("FAIL b2b_slot%0d we=%b data=%h exp we=%b data=%h",
                                   i, out_we, out_data[32*i +: 32], 8'h1 << i, exp_v);
            end
        end
        iobus_wr = 1'b0;
        tick();
        n_checks++;
        if (out_we !== 8'h0 || out_data !== {model_out[7], model_out[6], model_out[5], model_out[4],
                                             model_out[3], model_out[2], model_out[1], model_out[0]}) begin
            n_fail++; $display("FAIL b2b_final we=%b data=%h", out_we, out_data);
        end
        // Reset coinciding with a write and a pending interrupt
        bus_write(A_MASK, 32'hF);
        irq_src = 4'h2;
        iobus_addr = 32'h11000000;
        iobus_out  = 32'hCAFEF00D;
        iobus_wr   = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        iobus_wr = 1'b0;
        n_checks++;
        if (out_we !== 8'h0 || out_data !== 256'h0 || intr !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid we=%b intr=%b data=%h exp all zero", out_we, intr, out_data);
        end
        rst_n = 1'b1;
        tick();
        bus_read(A_PEND, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_pend got=%h exp=0", rd);
        end
        irq_src = 4'h0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_irq_basic();
        test_irq_masked();
        test_irq_collision();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
